// File: rtl/sm_add_sub_unit_pkg.sv
// Shared constants and types for the sign-magnitude add/sub slice of the small ALU.
// Imported by the top and by the testbench reference model.
package add_sub_pkg;

    localparam int WIDTH_DEFAULT = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Sign-magnitude result at the default width: one sign bit over a WIDTH-bit magnitude.
    typedef struct packed {
        logic                     sign;
        logic [WIDTH_DEFAULT-1:0] mag;
    } sm_t;

endpackage

// File: rtl/sm_add_sub_unit_if.sv
// Operand/result bus of sm_add_sub_unit. Handshake: a beat is accepted on every clock edge
// where in_valid is high; out_valid marks the cycle R/flags were updated; there is no backpressure.
interface sm_add_sub_unit_if #(
    parameter int WIDTH = 3
);

    logic             in_valid;
    logic             OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [WIDTH:0]   R;
    logic             SF;
    logic             ZF;
    logic             DZF;

    modport master (
        output in_valid, OP, A, B,
        input  out_valid, R, SF, ZF, DZF
    );

    modport slave (
        input  in_valid, OP, A, B,
        output out_valid, R, SF, ZF, DZF
    );

endinterface

// File: rtl/sm_add_sub_unit_mag_addsub.sv
// Combinational sign-magnitude core: effective signs and magnitudes in, normalised
// sign + magnitude out. A zero magnitude always leaves with sign 0.
module sm_mag_addsub #(
    parameter int WIDTH = 3
) (
    input  logic             s_a,
    input  logic [WIDTH-2:0] m_a,
    input  logic             s_b,
    input  logic [WIDTH-2:0] m_b,
    output logic             sign,
    output logic [WIDTH-1:0] mag
);

    logic [WIDTH-1:0] ext_a;
    logic [WIDTH-1:0] ext_b;

    assign ext_a = {1'b0, m_a};
    assign ext_b = {1'b0, m_b};

    always_comb begin
        sign = s_a;
        mag  = '0;
        if (s_a == s_b) begin
            mag  = ext_a + ext_b;
            sign = s_a;
        end else if (m_a >= m_b) begin
            mag  = ext_a - ext_b;
            sign = s_a;
        end else begin
            mag  = ext_b - ext_a;
            sign = s_b;
        end
        // Covers both 1-00..0 operands and cancelling differences.
        if (mag == '0) begin
            sign = 1'b0;
        end
    end

endmodule

// File: rtl/sm_add_sub_unit.sv
// Registered sign-magnitude adder/subtractor driving R and the SF/ZF/DZF flags.
// Define ADD_SUB_INPUT_REG_EN to add an input register stage (latency 2 instead of 1).
module sm_add_sub_unit
    import add_sub_pkg::*;
#(
    parameter int WIDTH = add_sub_pkg::WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    sm_add_sub_unit_if.slave   bus
);

    logic             dp_valid;
    logic             dp_op;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;

`ifdef ADD_SUB_INPUT_REG_EN
    logic             stg_valid_q, stg_valid_d;
    logic             stg_op_q,    stg_op_d;
    logic [WIDTH-1:0] stg_a_q,     stg_a_d;
    logic [WIDTH-1:0] stg_b_q,     stg_b_d;

    always_comb begin
        stg_valid_d = bus.in_valid;
        stg_op_d    = bus.OP;
        stg_a_d     = bus.A;
        stg_b_d     = bus.B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_q <= 1'b0;
            stg_op_q    <= OP_ADD;
            stg_a_q     <= '0;
            stg_b_q     <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_op_q    <= stg_op_d;
            stg_a_q     <= stg_a_d;
            stg_b_q     <= stg_b_d;
        end
    end

    assign dp_valid = stg_valid_q;
    assign dp_op    = stg_op_q;
    assign dp_a     = stg_a_q;
    assign dp_b     = stg_b_q;
`else
    assign dp_valid = bus.in_valid;
    assign dp_op    = bus.OP;
    assign dp_a     = bus.A;
    assign dp_b     = bus.B;
`endif

    logic             res_sign;
    logic [WIDTH-1:0] res_mag;

    // Subtraction is addition with B's sign flipped.
    sm_mag_addsub #(
        .WIDTH (WIDTH)
    ) u_mag_addsub (
        .s_a  (dp_a[WIDTH-1]),
        .m_a  (dp_a[WIDTH-2:0]),
        .s_b  (dp_b[WIDTH-1] ^ (dp_op == OP_SUB)),
        .m_b  (dp_b[WIDTH-2:0]),
        .sign (res_sign),
        .mag  (res_mag)
    );

    logic           out_valid_q, out_valid_d;
    logic [WIDTH:0] r_q,         r_d;
    logic           zf_q,        zf_d;

    always_comb begin
        out_valid_d = dp_valid;
        r_d         = r_q;
        zf_d        = zf_q;
        if (dp_valid) begin
            r_d  = {res_sign, res_mag};
            zf_d = (res_mag == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            zf_q        <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            zf_q        <= zf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.R         = r_q;
    assign bus.SF        = r_q[WIDTH];
    assign bus.ZF        = zf_q;
    assign bus.DZF       = 1'b0;

endmodule

// File: tb/tb_sm_add_sub_unit.sv
// Bench for sm_add_sub_unit: directed cases, exhaustive sweep, random stream and
// mid-stream resets, checked against a signed-integer reference model.
module tb_sm_add_sub_unit;
    import add_sub_pkg::*;

    localparam int W = add_sub_pkg::WIDTH_DEFAULT;
`ifdef ADD_SUB_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;

    sm_add_sub_unit_if #(.WIDTH(W)) bus ();

    sm_add_sub_unit #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: {valid, R, ZF} per accepted beat, pre-filled with LAT-1 idle beats
    logic [W+2:0] exp_q[$];
    sm_t          exp_r;
    logic         exp_zf;
    logic         exp_ov;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain signed-integer arithmetic, result re-encoded as sign-magnitude.
    function automatic logic [W+1:0] ref_model(input logic op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int va, vb, res, mag;
        logic neg;
        logic [W-1:0] m;
        va = int'(a[W-2:0]);
        if (a[W-1]) va = -va;
        vb = int'(b[W-2:0]);
        if (b[W-1]) vb = -vb;
        res = op ? (va - vb) : (va + vb);
        mag = (res < 0) ? -res : res;
        neg = (res < 0);
        m   = mag[W-1:0];
        return {neg, m, (mag == 0)};
    endfunction

    task automatic reset_model();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
        exp_r  = '0;
        exp_zf = 1'b1;
        exp_ov = 1'b0;
    endtask

    // driver: one clock of stimulus, then compare all outputs at the next falling edge
    task automatic step(input logic v, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+2:0] e;
        bus.in_valid = v;
        bus.OP       = op;
        bus.A        = a;
        bus.B        = b;
        exp_q.push_back({v, ref_model(op, a, b)});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        exp_ov = e[W+2];
        if (e[W+2]) begin
            exp_r  = e[W+1:1];
            exp_zf = e[0];
        end
        check_eq("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_ov});
        check_eq("R",         {{(31-W){1'b0}}, bus.R}, {{(31-W){1'b0}}, exp_r});
        check_eq("SF",        {31'b0, bus.SF}, {31'b0, exp_r.sign});
        check_eq("ZF",        {31'b0, bus.ZF}, {31'b0, exp_zf});
        check_eq("DZF",       {31'b0, bus.DZF}, 32'd0);
    endtask

    task automatic directed(input string tag, input logic op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W:0] r, input logic sf,
                            input logic zf);
        step(1'b1, op, a, b);
        for (int i = 0; i < LAT - 1; i++) step(1'b0, OP_ADD, '0, '0);
        check_eq({tag, "_R"},  {{(31-W){1'b0}}, bus.R}, {{(31-W){1'b0}}, r});
        check_eq({tag, "_SF"}, {31'b0, bus.SF}, {31'b0, sf});
        check_eq({tag, "_ZF"}, {31'b0, bus.ZF}, {31'b0, zf});
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check_eq({tag, "_R"},         {{(31-W){1'b0}}, bus.R}, 32'd0);
        check_eq({tag, "_SF"},        {31'b0, bus.SF}, 32'd0);
        check_eq({tag, "_ZF"},        {31'b0, bus.ZF}, 32'd1);
        check_eq({tag, "_DZF"},       {31'b0, bus.DZF}, 32'd0);
    endtask

    // Called right after a falling edge; reset lands between clock edges.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_state("midrst");
        bus.in_valid = 1'b0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        check_reset_state("midrst_hold");
        rst_n = 1'b1;
    endtask

    task automatic random_burst(input int n);
        for (int i = 0; i < n; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.OP       = OP_ADD;
        bus.A        = '0;
        bus.B        = '0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_state("por");
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        directed("add_m3_m3",  OP_ADD, 3'b111, 3'b111, 4'b1110, 1'b1, 1'b0);
        directed("add_m1_p3",  OP_ADD, 3'b101, 3'b011, 4'b0010, 1'b0, 1'b0);
        directed("sub_p2_p2",  OP_SUB, 3'b010, 3'b010, 4'b0000, 1'b0, 1'b1);
        directed("sub_p1_p3",  OP_SUB, 3'b001, 3'b011, 4'b1010, 1'b1, 1'b0);
        directed("sub_m2_m3",  OP_SUB, 3'b110, 3'b111, 4'b0001, 1'b0, 1'b0);
        directed("add_m0_p0",  OP_ADD, 3'b100, 3'b000, 4'b0000, 1'b0, 1'b1);

        // idle cycles: out_valid drops, R/flags hold
        step(1'b0, OP_ADD, 3'b011, 3'b011);
        step(1'b0, OP_SUB, 3'b001, 3'b111);

        // back-to-back sweep of the 7 non-negative-zero codes for both operands and both ops
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < (1 << W); a++) begin
                for (int b = 0; b < (1 << W); b++) begin
                    if (a != (1 << (W - 1)) && b != (1 << (W - 1))) begin
                        step(1'b1, 1'(op), W'(a), W'(b));
                    end
                end
            end
        end

        random_burst(150);
        step(1'b1, OP_ADD, 3'b011, 3'b010);
        mid_reset();
        random_burst(100);
        for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom_range(0, 1)),
                                         W'($urandom_range(0, 7)), W'($urandom_range(0, 7)));
        mid_reset();
        random_burst(100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
